// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one Duplex UART transmitter among NUM_REQ byte producers.
// Optional watchdog enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      uart_send,
    output logic [DATA_W-1:0]         uart_data,
    input  logic                      uart_tx_active,
    input  logic                      uart_tx_done,
    output logic                      busy,
    output logic                      timeout_flag
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ACT,
        WAIT_DONE,
        RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   pick;
    logic               pick_valid;
    logic [NUM_REQ-1:0] win_onehot;
    logic               timed_out;
    int unsigned        scan_idx;

    // First set request bit at or above rr_ptr, wrapping round to bit 0.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!pick_valid && req[scan_idx]) begin
                pick       = IDX_W'(scan_idx);
                pick_valid = 1'b1;
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << winner;
    assign busy       = (state != IDLE);

`ifdef UART_TX_TIMEOUT_EN
    logic [31:0] wd_cnt;

    assign timed_out = ((state == WAIT_ACT) || (state == WAIT_DONE)) &&
                       (wd_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == LOAD)
                wd_cnt <= '0;
            else if ((state == WAIT_ACT) || (state == WAIT_DONE))
                wd_cnt <= wd_cnt + 32'd1;
            if (timed_out)
                timeout_flag <= 1'b1;
        end
    end
`else
    // Watchdog absent: TIMEOUT_CYC is accepted only so overrides stay portable.
    assign timed_out    = (TIMEOUT_CYC == 0) & 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_valid) state_nxt = LOAD;
            LOAD:      state_nxt = WAIT_ACT;
            WAIT_ACT: begin
                // A finished frame wins over a late active flag so the grant is never stranded.
                if (timed_out || uart_tx_done) state_nxt = RELEASE;
                else if (uart_tx_active)       state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (timed_out || uart_tx_done) state_nxt = RELEASE;
            RELEASE:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant     <= '0;
            done      <= '0;
            uart_send <= 1'b0;
            uart_data <= '0;
            rr_ptr    <= '0;
            winner    <= '0;
        end else begin
            grant <= '0;
            done  <= '0;
            case (state)
                IDLE: if (pick_valid) winner <= pick;
                LOAD: begin
                    grant     <= win_onehot;
                    uart_data <= req_data[winner*DATA_W +: DATA_W];
                    uart_send <= 1'b1;
                end
                WAIT_ACT, WAIT_DONE: uart_send <= (state_nxt == WAIT_ACT);
                RELEASE: begin
                    done   <= win_onehot;
                    rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the Duplex handshake is driven by hand.
// Watchdog scenario follows UART_TX_TIMEOUT_EN as compiled.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      uart_send;
    logic [DATA_W-1:0]         uart_data;
    logic                      uart_tx_active;
    logic                      uart_tx_done;
    logic                      busy;
    logic                      timeout_flag;

    int checks_run = 0;
    int fail_count = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(100)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .done          (done),
        .uart_send     (uart_send),
        .uart_data     (uart_data),
        .uart_tx_active(uart_tx_active),
        .uart_tx_done  (uart_tx_done),
        .busy          (busy),
        .timeout_flag  (timeout_flag)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    // Waits for the grant, checks it, then completes the frame either via
    // active->done or via done alone, and checks the done pulse.
    task automatic run_frame(input string tag, input logic [NUM_REQ-1:0] exp_grant,
                             input logic [DATA_W-1:0] exp_data, input bit use_active);
        int lat = 0;
        while (grant == '0 && lat < 10) begin
            step(1);
            lat++;
        end
        check({tag, ".lat"}, lat, 2);
        check({tag, ".grant"}, grant, exp_grant);
        check({tag, ".data"}, uart_data, exp_data);
        check({tag, ".send"}, uart_send, 1);
        step(1);
        check({tag, ".grant_pulse"}, grant, 0);
        if (use_active) begin
            check({tag, ".send_held"}, uart_send, 1);
            uart_tx_active = 1'b1;
            step(1);
            check({tag, ".send_drop"}, uart_send, 0);
            uart_tx_active = 1'b0;
        end
        uart_tx_done = 1'b1;
        step(1);
        uart_tx_done = 1'b0;
        check({tag, ".done_early"}, done, 0);
        check({tag, ".busy_rel"}, busy, 1);
        step(1);
        check({tag, ".done"}, done, exp_grant);
        check({tag, ".busy_clr"}, busy, 0);
        check({tag, ".data_hold"}, uart_data, exp_data);
    endtask

    initial begin
        logic [NUM_REQ-1:0] done_seen;
        int cyc;

        reset_n        = 1'b0;
        req            = '0;
        req_data       = {8'h44, 8'h33, 8'h22, 8'hA5};
        uart_tx_active = 1'b0;
        uart_tx_done   = 1'b0;
        step(2);
        check("rst.grant", grant, 0);
        check("rst.done", done, 0);
        check("rst.send", uart_send, 0);
        check("rst.data", uart_data, 0);
        check("rst.busy", busy, 0);
        check("rst.timeout", timeout_flag, 0);
        reset_n = 1'b1;
        step(2);

        // Single request, latency and hold behaviour.
        req = 4'b0001;
        step(1);
        check("t1.load_busy", busy, 1);
        check("t1.load_grant", grant, 0);
        step(1);
        check("t1.grant", grant, 4'b0001);
        check("t1.data", uart_data, 8'hA5);
        check("t1.send", uart_send, 1);
        req      = '0;
        req_data = {8'h44, 8'h33, 8'h22, 8'hFF};
        step(3);
        check("t1.send_wait", uart_send, 1);
        check("t1.data_ignored", uart_data, 8'hA5);
        uart_tx_active = 1'b1;
        step(1);
        check("t1.send_drop", uart_send, 0);
        step(2);
        check("t1.no_done", done, 0);
        uart_tx_done = 1'b1;
        step(1);
        uart_tx_done   = 1'b0;
        uart_tx_active = 1'b0;
        check("t1.release", done, 0);
        step(1);
        check("t1.done", done, 4'b0001);
        check("t1.busy_clr", busy, 0);
        step(4);
        check("t1.idle_grant", grant, 0);
        check("t1.idle_busy", busy, 0);

        // Full rotation from a fresh pointer.
        apply_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b1111;
        run_frame("t2a", 4'b0001, 8'h11, 1'b1);
        run_frame("t2b", 4'b0010, 8'h22, 1'b0);
        run_frame("t2c", 4'b0100, 8'h33, 1'b1);
        run_frame("t2d", 4'b1000, 8'h44, 1'b0);
        run_frame("t2e", 4'b0001, 8'h11, 1'b1);

        // Wrap past the top requester; pointer then sits at 1.
        req = 4'b0100;
        run_frame("t3a", 4'b0100, 8'h33, 1'b1);
        req = 4'b0101;
        run_frame("t3b", 4'b0001, 8'h11, 1'b1);
        req = 4'b1001;
        run_frame("t3c", 4'b1000, 8'h44, 1'b0);

        // Asynchronous reset while waiting for the frame to finish.
        req = 4'b0010;
        step(2);
        check("t4.grant", grant, 4'b0010);
        req            = '0;
        uart_tx_active = 1'b1;
        step(1);
        uart_tx_active = 1'b0;
        check("t4.in_wait_done", busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t4.async_busy", busy, 0);
        check("t4.async_data", uart_data, 0);
        check("t4.async_send", uart_send, 0);
        step(2);
        reset_n = 1'b1;
        req     = 4'b0011;
        run_frame("t4b", 4'b0001, 8'h11, 1'b1);

        // Silent transmitter: watchdog fires or the arbiter waits forever.
        req = 4'b0100;
        step(2);
        check("t5.grant", grant, 4'b0100);
        req       = '0;
        done_seen = '0;
`ifdef UART_TX_TIMEOUT_EN
        cyc = 0;
        while (done == '0 && cyc < 300) begin
            step(1);
            cyc++;
            if (cyc == 99) check("t5.send_before", uart_send, 1);
        end
        check("t5.done_cycles", cyc, 101);
        check("t5.done", done, 4'b0100);
        check("t5.send_off", uart_send, 0);
        check("t5.flag", timeout_flag, 1);
        step(20);
        check("t5.flag_sticky", timeout_flag, 1);
        check("t5.busy", busy, 0);
`else
        for (int i = 0; i < 150; i++) begin
            step(1);
            done_seen |= done;
        end
        check("t6.no_done", done_seen, 0);
        check("t6.send_held", uart_send, 1);
        check("t6.busy", busy, 1);
        check("t6.flag", timeout_flag, 0);
        cyc = 0;
`endif
        apply_reset();
        check("end.flag_cleared", timeout_flag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_run, fail_count);
        $finish;
    end

endmodule
